// File: rtl/ifetch_issue_pkg.sv
// ifetch_issue_pkg: shared FSM states, tag width and FIFO entry layout for the fetch unit.
package ifetch_issue_pkg;
  localparam int TAG_WIDTH = 3;
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_e;
  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic [31:0]          pc;
    logic [31:0]          instr;
  } fifo_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: DEPTH-entry response buffer with flush; head is read straight from storage flops.
module ifetch_fifo
  import ifetch_issue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fifo_entry_t                  din,
  output fifo_entry_t                  head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  fifo_entry_t mem_q [DEPTH];
  fifo_entry_t mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign occ     = cnt_q;
  assign head    = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  always_comb begin
    mem_d = mem_q;
    if (do_push && !flush) mem_d[wr_q] = din;
    wr_d  = flush ? '0 : do_push ? nxt(wr_q) : wr_q;
    rd_d  = flush ? '0 : do_pop ? nxt(rd_q) : rd_q;
    cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ifetch_issue.sv
// ifetch_issue: credit-limited instruction fetch with jump flush and tagged in-order response buffer.
// Optional: define IFETCH_RVC_EN to honour jump_target_i[1] in the reported PC.
module ifetch_issue
  import ifetch_issue_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic                 jump_i,
  input  logic [31:0]          jump_target_i,
  output logic                 imem_req_o,
  output logic [31:0]          imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [31:0]          imem_rdata_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [TAG_WIDTH-1:0] tag_o,
  output logic [31:0]          pc_o,
  output logic [31:0]          instruction_o
);
  localparam int CW = $clog2(DEPTH+1);
  state_e state_q, state_d;
  logic [31:0] fetch_q, fetch_d, resp_pc_q, resp_pc_d, tgt_pc, tgt_addr;
  logic [CW-1:0] inflight_q, inflight_d, drop_q, drop_d, occ;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic jump, issue, push, pop, full, empty;
  fifo_entry_t din, head;
`ifdef IFETCH_RVC_EN
  assign tgt_pc = jump_target_i & ~32'h1;
`else
  assign tgt_pc = jump_target_i & ~32'h3;
`endif
  assign tgt_addr    = jump_target_i & ~32'h3;
  assign jump        = jump_i & (state_q != BOOT);
  assign imem_req_o  = (state_q != BOOT) & ~jump_i &
                       (({1'b0, inflight_q} + {1'b0, occ}) < (CW+1)'(DEPTH));
  assign imem_addr_o = fetch_q;
  assign issue       = imem_req_o & imem_gnt_i;
  assign push        = imem_rvalid_i & (drop_q == '0) & ~jump & ~full;
  assign pop         = ~empty & ready_i & enable_i & ~jump;
  assign din         = '{tag: tag_q, pc: resp_pc_q, instr: imem_rdata_i};
  assign valid_o       = ~empty;
  assign tag_o         = head.tag;
  assign pc_o          = head.pc;
  assign instruction_o = head.instr;
  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(jump), .din(din),
    .head(head), .full(full), .empty(empty), .occ(occ)
  );
  always_comb begin
    inflight_d = inflight_q + CW'(issue) - CW'(imem_rvalid_i);
    state_d    = state_q;
    fetch_d    = issue ? fetch_q + 32'd4 : fetch_q;
    resp_pc_d  = push ? {resp_pc_q[31:2], 2'b00} + 32'd4 : resp_pc_q;
    drop_d     = (imem_rvalid_i && drop_q != '0) ? drop_q - 1'b1 : drop_q;
    tag_d      = tag_q;
    if (state_q == BOOT) begin
      state_d   = RUN;
      fetch_d   = BOOT_ADDR;
      resp_pc_d = BOOT_ADDR;
    end else if (jump) begin
      // responses still owed to the old stream must be swallowed
      tag_d     = tag_q + 1'b1;
      fetch_d   = tgt_addr;
      resp_pc_d = tgt_pc;
      drop_d    = inflight_d;
      state_d   = inflight_d != '0 ? FLUSH : RUN;
    end else if (state_q == FLUSH && drop_d == '0) begin
      state_d   = RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      fetch_q    <= BOOT_ADDR;
      resp_pc_q  <= BOOT_ADDR;
      inflight_q <= '0;
      drop_q     <= '0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_q    <= fetch_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      tag_q      <= tag_d;
    end
  end
endmodule

// File: tb/tb_ifetch_issue.sv
// tb_ifetch_issue: directed checks of fetch issue, credit limit, jump flush and tagging.
module tb_ifetch_issue;
  import ifetch_issue_pkg::*;
  logic clk = 0, reset = 1, enable_i = 1, jump_i = 0, imem_gnt_i = 1, ready_i = 1;
  logic imem_rvalid_i = 0;
  logic [31:0] jump_target_i = 0, imem_rdata_i = 0;
  logic imem_req_o, valid_o;
  logic [31:0] imem_addr_o, pc_o, instruction_o;
  logic [2:0] tag_o;
  int checks = 0, errors = 0, issues = 0;
  bit hold = 0;
  logic [31:0] q[$];
  logic [31:0] pcs[$];
  ifetch_issue dut (
    .clk(clk), .reset(reset), .enable_i(enable_i), .jump_i(jump_i), .jump_target_i(jump_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .valid_o(valid_o),
    .ready_i(ready_i), .tag_o(tag_o), .pc_o(pc_o), .instruction_o(instruction_o)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rd(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic mem_drive();
    imem_rvalid_i = !hold && !reset && q.size() > 0;
    imem_rdata_i  = q.size() > 0 ? rd(q[0]) : 32'h0;
  endtask
  task automatic step();
    bit iss, rv;
    logic [31:0] ia;
    #1;
    iss = imem_req_o & imem_gnt_i;
    ia  = imem_addr_o;
    rv  = imem_rvalid_i;
    @(posedge clk);
    #1;
    if (reset) q.delete();
    else begin
      if (rv) void'(q.pop_front());
      if (iss) begin q.push_back(ia); issues++; end
    end
    mem_drive();
  endtask
  task automatic do_reset();
    reset = 1; jump_i = 0; hold = 0;
    step(); step();
    reset = 0;
    mem_drive();
  endtask
  task automatic wait_valid(input string tag);
    int n = 0;
    #1;
    while (!valid_o && n < 40) begin step(); n++; end
    chk({tag, "_vld"}, 32'(valid_o), 32'd1);
  endtask
  task automatic jump_to(input logic [31:0] t);
    jump_i = 1; jump_target_i = t;
    step();
    jump_i = 0;
    #1;
  endtask
  initial begin
    // reset values
    step(); step();
    chk("rst_req", 32'(imem_req_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_tag", 32'(tag_o), 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_instr", instruction_o, 0);
    // streaming after reset release: BOOT cycle, then fetch 0,4,8
    reset = 0; mem_drive(); #1;
    chk("boot_noreq", 32'(imem_req_o), 0);
    step();
    chk("c1_req", 32'(imem_req_o), 1);
    chk("c1_addr", imem_addr_o, 32'h0);
    step();
    chk("c2_addr", imem_addr_o, 32'h4);
    chk("c2_novalid", 32'(valid_o), 0);
    step();
    chk("c3_valid", 32'(valid_o), 1);
    chk("c3_tag", 32'(tag_o), 0);
    chk("c3_instr", instruction_o, rd(32'h0));
    pcs.delete();
    for (int i = 0; i < 20 && pcs.size() < 3; i++) begin
      if (valid_o) pcs.push_back(pc_o);
      step();
    end
    chk("seq_n", pcs.size(), 3);
    for (int i = 0; i < pcs.size(); i++) chk("seq_pc", pcs[i], 32'(4 * i));
    // credit limit with consumer stalled
    do_reset();
    ready_i = 0; issues = 0;
    for (int i = 0; i < 8; i++) step();
    chk("cred_issues", issues, 2);
    chk("cred_noreq", 32'(imem_req_o), 0);
    ready_i = 1; step(); ready_i = 0; issues = 0;
    for (int i = 0; i < 6; i++) step();
    chk("cred_one_more", issues, 1);
    enable_i = 0; ready_i = 1; step();
    chk("en_hold_valid", 32'(valid_o), 1);
    chk("en_hold_pc", pc_o, 32'h4);
    enable_i = 1;
    // jump with two requests in flight
    do_reset();
    hold = 1;
    step(); step(); step();
    chk("fl_noreq", 32'(imem_req_o), 0);
    jump_to(32'h100);
    chk("fl_state", 32'(dut.state_q), 32'(FLUSH));
    chk("fl_addr", imem_addr_o, 32'h100);
    hold = 0; mem_drive();
    wait_valid("fl");
    chk("fl_pc", pc_o, 32'h100);
    chk("fl_tag", 32'(tag_o), 1);
    chk("fl_instr", instruction_o, rd(32'h100));
    // jump coincident with response and pop
    do_reset();
    step(); step(); step();
    chk("co_pre_valid", 32'(valid_o), 1);
    issues = 0;
    jump_i = 1; jump_target_i = 32'h300; #1;
    chk("co_noreq", 32'(imem_req_o), 0);
    step();
    jump_i = 0; #1;
    chk("co_noissue", issues, 0);
    chk("co_empty", 32'(valid_o), 0);
    chk("co_addr", imem_addr_o, 32'h300);
    chk("co_state", 32'(dut.state_q), 32'(RUN));
    wait_valid("co");
    chk("co_pc", pc_o, 32'h300);
    // eight jumps wrap the tag
    do_reset();
    step(); step();
    for (int i = 0; i < 8; i++) begin
      jump_to(32'h1000 + 32'(i) * 32'h40);
      wait_valid("tg");
      chk("tg_tag", 32'(tag_o), 32'((i + 1) % 8));
      chk("tg_pc", pc_o, 32'h1000 + 32'(i) * 32'h40);
    end
    // half-word jump target
    jump_to(32'h202);
    chk("rvc_addr", imem_addr_o, 32'h200);
    wait_valid("rvc0");
`ifdef IFETCH_RVC_EN
    chk("rvc_pc0", pc_o, 32'h202);
`else
    chk("rvc_pc0", pc_o, 32'h200);
`endif
    step();
    wait_valid("rvc1");
    chk("rvc_pc1", pc_o, 32'h204);
    // address wrap
    jump_to(32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    wait_valid("wrap0");
    chk("wrap_pc0", pc_o, 32'hFFFF_FFFC);
    step();
    wait_valid("wrap1");
    chk("wrap_pc1", pc_o, 32'h0);
    // reset in the middle of traffic with buffered data
    ready_i = 0; hold = 0;
    for (int i = 0; i < 4; i++) step();
    reset = 1; step();
    chk("mid_valid", 32'(valid_o), 0);
    chk("mid_tag", 32'(tag_o), 0);
    chk("mid_pc", pc_o, 0);
    chk("mid_req", 32'(imem_req_o), 0);
    ready_i = 1;
    do_reset();
    wait_valid("mid");
    chk("mid_first_pc", pc_o, 32'h0);
    chk("mid_first_tag", 32'(tag_o), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
